// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one 32-bit memory port between the instruction-fetch
//               requester (IF) and the load/store requester (D). Each access
//               runs grant -> bus phase -> ack. D wins simultaneous requests
//               until it has taken STARVE_LIM grants in a row while IF was
//               waiting; the next grant then goes to IF. A bus phase that sees
//               no mem_ready for MAX_WAIT cycles is aborted with rdata = 0 and
//               a timeout_err pulse.
// Ports       : clk, rst_n            clock, async active-low reset
//               if_req/if_addr        IF read request (held until if_ack)
//               if_ack/if_rdata       IF completion pulse and read data
//               d_req/d_we/d_be/
//               d_addr/d_wdata        D request (held until d_ack)
//               d_ack/d_rdata         D completion pulse and read data
//               mem_req/mem_we/mem_be/
//               mem_addr/mem_wdata    memory port strobe and fields
//               mem_rdata/mem_ready   memory read data and completion
//               sel                   port mux select, 0 = IF, 1 = D
//               timeout_err           pulse when an access is aborted
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_LIM = 4,
    parameter int MAX_WAIT   = 15,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        sel,
    output logic        timeout_err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUS  = 2'd1;
    localparam logic [1:0] c_ACK  = 2'd2;

    localparam logic [CNT_W-1:0] c_STARVE_LIM = CNT_W'(STARVE_LIM);
    localparam logic [CNT_W-1:0] c_WAIT_LAST  = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [3:0]       r_mem_be;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic             r_sel;
    logic             r_if_ack;
    logic             r_d_ack;
    logic [31:0]      r_if_rdata;
    logic [31:0]      r_d_rdata;
    logic             r_timeout_err;

    logic             w_grant_d;
    logic             w_grant_if;
    logic             w_contended;

    // D wins unless IF is also waiting and D has used up its run of grants.
    assign w_contended = if_req && d_req;
    assign w_grant_d   = d_req && (!if_req || (r_starve_cnt < c_STARVE_LIM));
    assign w_grant_if  = if_req && !w_grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_starve_cnt  <= '0;
            r_wait_cnt    <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_be      <= 4'h0;
            r_mem_addr    <= 32'h0;
            r_mem_wdata   <= 32'h0;
            r_sel         <= 1'b0;
            r_if_ack      <= 1'b0;
            r_d_ack       <= 1'b0;
            r_if_rdata    <= 32'h0;
            r_d_rdata     <= 32'h0;
            r_timeout_err <= 1'b0;
        end else begin
            // Acks and the error flag are single-cycle pulses.
            r_if_ack      <= 1'b0;
            r_d_ack       <= 1'b0;
            r_timeout_err <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    r_mem_req <= 1'b0;
                    if (w_grant_d) begin
                        r_sel       <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_be    <= d_be;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_mem_req   <= 1'b1;
                        r_wait_cnt  <= '0;
                        r_state     <= c_BUS;
                        // Only grants taken over a waiting IF count toward starvation.
                        if (w_contended && (r_starve_cnt != c_CNT_MAX)) begin
                            r_starve_cnt <= r_starve_cnt + c_CNT_ONE;
                        end
                    end else if (w_grant_if) begin
                        r_sel        <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_mem_be     <= 4'hF;
                        r_mem_addr   <= if_addr;
                        r_mem_wdata  <= 32'h0;
                        r_mem_req    <= 1'b1;
                        r_wait_cnt   <= '0;
                        r_starve_cnt <= '0;
                        r_state      <= c_BUS;
                    end
                end

                c_BUS: begin
                    if (mem_ready) begin
                        if (r_sel) begin
                            r_d_rdata <= mem_rdata;
                            r_d_ack   <= 1'b1;
                        end else begin
                            r_if_rdata <= mem_rdata;
                            r_if_ack   <= 1'b1;
                        end
                        r_mem_req <= 1'b0;
                        r_state   <= c_ACK;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        // Abort: complete the access with zero data and flag it.
                        if (r_sel) begin
                            r_d_rdata <= 32'h0;
                            r_d_ack   <= 1'b1;
                        end else begin
                            r_if_rdata <= 32'h0;
                            r_if_ack   <= 1'b1;
                        end
                        r_timeout_err <= 1'b1;
                        r_mem_req     <= 1'b0;
                        r_state       <= c_ACK;
                    end else if (r_wait_cnt != c_CNT_MAX) begin
                        r_wait_cnt <= r_wait_cnt + c_CNT_ONE;
                    end
                end

                c_ACK: begin
                    // Requests are not looked at here; the requester drops req this edge.
                    r_mem_req <= 1'b0;
                    r_state   <= c_IDLE;
                end

                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= c_IDLE;
                end
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_be      = r_mem_be;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign sel         = r_sel;
    assign if_ack      = r_if_ack;
    assign d_ack       = r_d_ack;
    assign if_rdata    = r_if_rdata;
    assign d_rdata     = r_d_rdata;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Single-requester
//               accesses come from a table of hand-computed vectors; the
//               arbitration run, timeout, mid-access reset and ignored
//               mem_ready/ACK-cycle request cases are written out by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        sel;
    logic        timeout_err;

    int n_chk;
    int n_fail;

    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;

    mem_port_arbiter #(
        .STARVE_LIM(4),
        .MAX_WAIT  (15),
        .CNT_W     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ack     (if_ack),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_be       (d_be),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ack      (d_ack),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .sel        (sel),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waitn;
        logic [31:0] rdata;
        logic        exp_sel;
        logic        exp_we;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        d_req     = 1'b0;
        mem_ready = 1'b0;
    endtask

    // Called with the DUT in IDLE, just after an edge.
    task automatic run_vec(input vec_t v);
        if (v.is_d) begin
            d_req   = 1'b1;
            d_we    = v.we;
            d_be    = v.be;
            d_addr  = v.addr;
            d_wdata = v.wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end
        mem_ready = 1'b0;
        step();
        for (int k = 0; k <= v.waitn; k++) begin
            chk("bus_mem_req", {31'd0, mem_req}, 32'd1);
            chk("bus_sel", {31'd0, sel}, {31'd0, v.exp_sel});
            chk("bus_addr", mem_addr, v.addr);
            chk("bus_we", {31'd0, mem_we}, {31'd0, v.exp_we});
            chk("bus_be", {28'd0, mem_be}, {28'd0, v.exp_be});
            if (v.is_d) chk("bus_wdata", mem_wdata, v.wdata);
            chk("bus_no_ack", {30'd0, if_ack, d_ack}, 32'd0);
            if (k == v.waitn) begin
                mem_ready = 1'b1;
                mem_rdata = v.rdata;
            end
            step();
        end
        if (v.is_d) exp_d_rdata = v.rdata;
        else        exp_if_rdata = v.rdata;
        chk("ack_mem_req", {31'd0, mem_req}, 32'd0);
        chk("ack_if", {31'd0, if_ack}, {31'd0, !v.is_d});
        chk("ack_d", {31'd0, d_ack}, {31'd0, v.is_d});
        chk("ack_sel", {31'd0, sel}, {31'd0, v.exp_sel});
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        chk("ack_timeout", {31'd0, timeout_err}, 32'd0);
        idle_inputs();
        step();
        chk("post_ack_clear", {30'd0, if_ack, d_ack}, 32'd0);
    endtask

    logic exp_order[10];
    int   cyc;

    initial begin
        n_chk        = 0;
        n_fail       = 0;
        exp_if_rdata = 32'h0;
        exp_d_rdata  = 32'h0;
        if_addr      = 32'h0;
        d_we         = 1'b0;
        d_be         = 4'h0;
        d_addr       = 32'h0;
        d_wdata      = 32'h0;
        mem_rdata    = 32'h0;
        idle_inputs();
        rst_n = 1'b0;

        //                 is_d  we    be     addr          wdata         wait rdata         sel   we    be
        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0040, 32'h0,        0, 32'h2402_0005, 1'b0, 1'b0, 4'hF};
        vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h0000_0000, 1'b1, 1'b1, 4'h3};
        vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0,        1, 32'h1234_5678, 1'b1, 1'b0, 4'hF};
        vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h0000_0044, 32'h0,        3, 32'hCAFE_F00D, 1'b0, 1'b0, 4'hF};
        vecs[4] = '{1'b1, 1'b1, 4'hC, 32'h0000_0300, 32'h5555_AAAA, 0, 32'h0BAD_0001, 1'b1, 1'b1, 4'hC};

        // Reset state
        repeat (3) step();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_sel", {31'd0, sel}, 32'd0);
        chk("rst_acks", {29'd0, if_ack, d_ack, timeout_err}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        #4 rst_n = 1'b1;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Both requesters held high: D,D,D,D,IF repeating
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        if_req    = 1'b1;
        if_addr   = 32'h0000_0080;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_be      = 4'hF;
        d_addr    = 32'h0000_0400;
        mem_ready = 1'b1;
        mem_rdata = 32'hA5A5_0000;
        for (int t = 0; t < 10; t++) begin
            step();
            chk("arb_mem_req", {31'd0, mem_req}, 32'd1);
            chk("arb_sel", {31'd0, sel}, {31'd0, exp_order[t]});
            chk("arb_addr", mem_addr, exp_order[t] ? 32'h0000_0400 : 32'h0000_0080);
            step();
            chk("arb_ack", {30'd0, if_ack, d_ack}, {30'd0, !exp_order[t], exp_order[t]});
            step();
        end
        exp_if_rdata = 32'hA5A5_0000;
        exp_d_rdata  = 32'hA5A5_0000;
        idle_inputs();
        step();

        // Timeout on a D read: 15 bus cycles, then zero data with timeout_err
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h0000_0500;
        mem_rdata = 32'hFFFF_FFFF;
        step();
        cyc = 0;
        while (mem_req === 1'b1 && cyc < 40) begin
            chk("to_no_ack", {30'd0, if_ack, d_ack}, 32'd0);
            cyc++;
            step();
        end
        chk("to_bus_cycles", cyc, 32'd15);
        chk("to_d_ack", {31'd0, d_ack}, 32'd1);
        chk("to_err", {31'd0, timeout_err}, 32'd1);
        chk("to_d_rdata", d_rdata, 32'd0);
        exp_d_rdata = 32'h0;
        idle_inputs();
        step();
        chk("to_idle", {29'd0, mem_req, d_ack, timeout_err}, 32'd0);

        // Async reset in the middle of a D access
        d_req  = 1'b1;
        d_addr = 32'h0000_0600;
        step();
        step();
        chk("mr_bus", {31'd0, mem_req}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_async_drop", {31'd0, mem_req}, 32'd0);
        chk("mr_sel", {31'd0, sel}, 32'd0);
        exp_if_rdata = 32'h0;
        idle_inputs();
        step();
        #4 rst_n = 1'b1;
        step();
        chk("mr_no_ack", {30'd0, if_ack, d_ack}, 32'd0);
        run_vec(vecs[0]);

        // mem_ready outside BUS is ignored; a request raised in ACK waits for IDLE
        mem_ready = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        step();
        step();
        chk("sp_idle_req", {31'd0, mem_req}, 32'd0);
        chk("sp_if_rdata", if_rdata, exp_if_rdata);
        chk("sp_d_rdata", d_rdata, exp_d_rdata);
        chk("sp_acks", {30'd0, if_ack, d_ack}, 32'd0);
        d_req     = 1'b1;
        d_addr    = 32'h0000_0700;
        mem_rdata = 32'h7777_0007;
        step();
        step();
        chk("sp_ack_d", {31'd0, d_ack}, 32'd1);
        exp_d_rdata = 32'h7777_0007;
        d_req     = 1'b0;
        if_req    = 1'b1;
        if_addr   = 32'h0000_0090;
        mem_rdata = 32'hBAD1_BAD1;
        step();
        chk("sp_back_idle", {31'd0, mem_req}, 32'd0);
        chk("sp_no_if_ack", {31'd0, if_ack}, 32'd0);
        chk("sp_if_hold", if_rdata, exp_if_rdata);
        step();
        chk("sp_grant_req", {31'd0, mem_req}, 32'd1);
        chk("sp_grant_sel", {31'd0, sel}, 32'd0);
        chk("sp_grant_addr", mem_addr, 32'h0000_0090);
        mem_rdata = 32'h0000_9090;
        step();
        chk("sp_if_ack", {31'd0, if_ack}, 32'd1);
        chk("sp_if_rdata2", if_rdata, 32'h0000_9090);
        chk("sp_d_hold", d_rdata, exp_d_rdata);
        idle_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 32-bit memory port between the instruction-fetch requester (IF) and the load/store requester (D).
- Sequences each access as grant -> bus phase -> ack.
- Drives the select line of the address/data 2:1 muxes in front of the port.
- Sits between the fetch/memory pipeline stages and the unified memory interface.

Parameters:
- STARVE_LIM, 4: max consecutive D grants while IF is waiting; after that, IF is forced.
- MAX_WAIT, 15: bus-phase cycles without mem_ready before the access is aborted.
- CNT_W, 4: width of the starvation and wait counters; must hold STARVE_LIM and MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  IF read request; held high until if_ack
- if_addr  in  32  IF word address
- if_ack  out  1  one-cycle completion pulse to IF
- if_rdata  out  32  read data to IF; valid while if_ack=1
- d_req  in  1  D request; held high until d_ack
- d_we  in  1  D write enable
- d_be  in  4  D byte enables
- d_addr  in  32  D address
- d_wdata  in  32  D write data
- d_ack  out  1  one-cycle completion pulse to D
- d_rdata  out  32  read data to D; valid while d_ack=1
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data; sampled when mem_ready=1
- mem_ready  in  1  memory completion
- sel  out  1  mux control: 0 = IF owns the port, 1 = D owns the port
- timeout_err  out  1  one-cycle pulse when an access is aborted on MAX_WAIT

Behaviour:
Reset:
- rst_n=0 immediately forces state IDLE, regardless of clock.
- Outputs under reset: mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, sel=0, if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, timeout_err=0.
- Starvation and wait counters clear to 0.
- Reset during the bus phase drops mem_req asynchronously; no ack is issued.

FSM states: IDLE, BUS, ACK.

IDLE:
- mem_req=0.
- If neither request is high, stay in IDLE.
- If only one request is high, grant it.
- If both are high:
  - grant D when starve_cnt < STARVE_LIM, and increment starve_cnt;
  - otherwise grant IF.
- Any IF grant clears starve_cnt to 0.
- A D grant with if_req=0 leaves starve_cnt unchanged.
- On a grant: register sel, latch the winner's addr/we/be/wdata into the mem_* output registers, clear wait_cnt, go to BUS.
- IF accesses always drive mem_we=0 and mem_be=4'hF.

BUS:
- mem_req=1; all mem_* outputs and sel hold stable for the whole phase.
- mem_ready=1: capture mem_rdata into the granted requester's rdata register, go to ACK.
- Else if wait_cnt == MAX_WAIT-1: load rdata=0, pulse timeout_err in the ACK cycle, go to ACK.
- Else increment wait_cnt.

ACK:
- mem_req=0; exactly one of if_ack/d_ack is 1, matching sel.
- sel is held.
- Next state is IDLE unconditionally.
- Requests are not evaluated in ACK.

Requester contract:
- A requester deasserts req on the edge that samples its ack=1.
- Any req that is high in IDLE is a new request.
- Fields must stay stable from req rise until ack.

Timing:
- Minimum latency is 3 cycles from req sampled in IDLE to the ack cycle (grant edge, one BUS cycle, ACK).
- Each extra wait cycle adds 1.
- Back-to-back accesses repeat IDLE -> BUS -> ACK -> IDLE, one transaction every 3 cycles minimum.

Other rules:
- rdata registers hold their value between acks.
- mem_ready is ignored outside BUS.
- A simultaneous if_req and d_req rise is arbitrated by the starvation rule only; there is no round-robin.
- Counters saturate and never wrap.

Test Plan:
- Reset, then single IF read to addr 0x0000_0040 with mem_ready one cycle after mem_req and mem_rdata=0x2402_0005 -> sel=0, mem_addr=0x40, mem_we=0, mem_be=F; if_ack pulses 3 cycles after request; if_rdata=0x2402_0005.
- Single D write to addr 0x100, wdata=0xDEAD_BEEF, be=4'b0011, mem_ready after 2 wait cycles -> sel=1, mem_we=1, mem_be=3; outputs stable 3 cycles; d_ack at cycle 5; if_ack stays 0.
- if_req and d_req both held continuously (each re-raised after ack), STARVE_LIM=4, zero wait -> grant order D,D,D,D,IF,D,D,D,D,IF; starve_cnt returns to 0 after each IF grant.
- D read with mem_ready never asserted, MAX_WAIT=15 -> mem_req high exactly 15 cycles; then d_ack=1, d_rdata=0, and timeout_err=1 in the same cycle; FSM returns to IDLE.
- rst_n pulled low mid-BUS (cycle 2 of a D access) -> mem_req falls without a clock edge; no d_ack; after release, a new IF request completes normally.
- mem_ready=1 while in IDLE/ACK, and a req raised during ACK -> no spurious capture; the new request is granted on the edge after returning to IDLE.
